matrix_anim_seq: RTL and testbench
==================================

Name: matrix_anim_seq

Overview:
Wishbone master that drives the 8x8 LED matrix driver's register slave port. Once per frame period it rewrites all eight row registers with a rotating nibble pattern, so the matrix shows a diagonal scroll with no CPU involvement. It issues one single-beat write at a time, handles stall and ack, and aborts on an ack timeout. It sits between top-level control switches and the matrix driver's slave port.

Parameters:
WB_DATA_WIDTH, 32, data bus width; one row of 8 nibbles (0bxRGB).
WB_ADDR_WIDTH, 3, row address width (8 rows).
WB_SEL_WIDTH, WB_DATA_WIDTH/8, byte-select width.
FRAME_TICKS, 1000000, idle clk cycles between the end of one frame write and the start of the next; must be >= 1.
ACK_TIMEOUT, 16, maximum clk cycles a row transaction may remain open before it is aborted.
SEED, 32'h12345671, base row pattern.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
i_enable  in  1  run the animation while high
i_clear_err  in  1  clears a sticky error and leaves the ERROR state
o_wb_cyc  out  1  bus cycle
o_wb_stb  out  1  strobe
o_wb_we  out  1  write enable; always 1 while o_wb_stb is high
o_wb_addr  out  WB_ADDR_WIDTH  row number
o_wb_sel  out  WB_SEL_WIDTH  all ones while o_wb_stb is high
o_wb_wdata  out  WB_DATA_WIDTH  row pattern
i_wb_ack  in  1  slave ack
i_wb_stall  in  1  slave stall
o_busy  out  1  high in ISSUE and ACK_WAIT
o_frame_done  out  1  one-cycle pulse after row 7 is acked
o_error  out  1  sticky timeout flag
o_frame_count  out  8  completed frames; wraps 255->0

Behaviour:
- Reset is asynchronous. All outputs go to 0 immediately, including a mid-transaction o_wb_cyc. State = IDLE; row, frame counter and tick counter are cleared.
- Pattern: wdata(row r, frame f) = SEED rotated left by 4*((r + f[2:0]) mod 8) bits.
  - Example for SEED 0x12345671: r0f0 = 0x12345671, r1f0 = 0x23456711, r7f0 = 0x11234567, r0f1 = 0x23456711.
- States: IDLE, ISSUE, ACK_WAIT, DONE, WAIT, ERROR.
- IDLE: all bus outputs 0. If i_enable=1, go to ISSUE with row = 0.
- ISSUE: o_wb_cyc = o_wb_stb = 1; addr, wdata and sel are driven.
  - Addr, wdata and sel are held stable while i_wb_stall=1.
  - On a clock edge with stall=0, go to ACK_WAIT.
  - If i_wb_ack=1 on that same edge, the row is treated as complete immediately, exactly as in ACK_WAIT.
- ACK_WAIT: o_wb_cyc = 1, o_wb_stb = 0.
  - On ack with row < 7: row+1, go to ISSUE next cycle.
  - On ack with row = 7: go to DONE.
- Only one transaction is ever outstanding.
- Timeout counter: reset at entry to each row's ISSUE and incremented every cycle in ISSUE and ACK_WAIT. When it reaches ACK_TIMEOUT with no ack:
  - o_wb_cyc and o_wb_stb drop on the next cycle;
  - o_error = 1;
  - go to ERROR. The frame counter is not incremented.
- ERROR: bus idle. If i_clear_err=1, o_error <= 0 and go to IDLE. If i_clear_err is held across reset, reset wins.
- DONE: one cycle. o_frame_done = 1, o_frame_count + 1, cyc = 0.
  - If i_enable=1, go to WAIT with the tick counter = FRAME_TICKS-1.
  - Otherwise go to IDLE.
- WAIT: decrement the tick counter.
  - At 0, go to ISSUE with row = 0.
  - If i_enable=0 at any point, go to IDLE immediately.
- i_enable deasserted during ISSUE or ACK_WAIT does not abort. The frame completes through DONE, then the block goes to IDLE.
- Timing with a zero-stall, 1-cycle-ack slave:
  - 2 cycles per row; DONE occurs 16 cycles after the first ISSUE.
  - Frame start-to-start = 17 + FRAME_TICKS cycles.
- A late ack arriving in IDLE, WAIT, DONE or ERROR is ignored.

Test Plan:
- Nominal frame: FRAME_TICKS = 20, ideal slave (stall=0, ack 1 cycle after stb), i_enable=1 -> 8 writes with addr 0..7 and wdata 0x12345671, 0x23456711, …, 0x11234567; o_frame_done pulses on cycle 16; next ISSUE exactly 37 cycles after the first.
- Second frame and wrap: run 9 frames -> frame 1 row 0 wdata = 0x23456711; frame 8 wdata equals frame 0; o_frame_count = 9.
- Stall: slave stalls 3 cycles on row 2 -> stb, addr and wdata are held stable for 4 cycles; no duplicate write; frame completes 3 cycles later than nominal.
- Timeout: slave never acks row 4 -> cyc drops after 16 cycles; o_error = 1; state ERROR; o_frame_count unchanged; i_clear_err pulse -> o_error = 0 and a new frame starts from row 0.
- Enable drop: i_enable -> 0 during row 3 -> rows 4..7 are still written, o_frame_done pulses, then no further bus activity; i_enable -> 0 during WAIT -> IDLE next cycle.
- Async reset mid-transaction: assert reset while cyc=1 -> o_wb_cyc = 0 in the same cycle; after release with i_enable=1, the frame restarts at row 0 with f = 0.

Source files
------------

// File: rtl/matrix_anim_seq_if.sv
// Wishbone write-only bus between matrix_anim_seq (master) and the LED matrix
// driver's register slave port.
//   cyc, stb, we, addr, sel, wdata : master -> slave
//   ack, stall                     : slave -> master
interface matrix_anim_seq_if #(
    parameter int unsigned WB_DATA_WIDTH = 32,
    parameter int unsigned WB_ADDR_WIDTH = 3,
    parameter int unsigned WB_SEL_WIDTH  = WB_DATA_WIDTH / 8
);
    logic                     cyc;
    logic                     stb;
    logic                     we;
    logic [WB_ADDR_WIDTH-1:0] addr;
    logic [WB_SEL_WIDTH-1:0]  sel;
    logic [WB_DATA_WIDTH-1:0] wdata;
    logic                     ack;
    logic                     stall;

    modport master (
        output cyc, stb, we, addr, sel, wdata,
        input  ack, stall
    );

    modport slave (
        input  cyc, stb, we, addr, sel, wdata,
        output ack, stall
    );
endinterface

// File: rtl/matrix_anim_seq.sv
// Wishbone master that rewrites the 8 row registers of the LED matrix driver
// once per frame period with a rotating nibble pattern (diagonal scroll).
// One single-beat write is outstanding at a time; a row that stays open for
// ACK_TIMEOUT cycles without an ack aborts the frame into a sticky error.
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   i_enable       : run the animation while high
//   i_clear_err    : clear the sticky error and return to idle
//   wb             : Wishbone master port (cyc/stb/we/addr/sel/wdata, ack/stall)
//   o_busy         : a row transaction is in progress
//   o_frame_done   : one-cycle pulse after row 7 is acked
//   o_error        : sticky ack-timeout flag
//   o_frame_count  : completed frames, wraps 255 -> 0
module matrix_anim_seq #(
    parameter int unsigned              WB_DATA_WIDTH = 32,
    parameter int unsigned              WB_ADDR_WIDTH = 3,
    parameter int unsigned              WB_SEL_WIDTH  = WB_DATA_WIDTH / 8,
    parameter int unsigned              FRAME_TICKS   = 1000000,
    parameter int unsigned              ACK_TIMEOUT   = 16,
    parameter logic [WB_DATA_WIDTH-1:0] SEED          = 32'h12345671
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_enable,
    input  logic                     i_clear_err,
    matrix_anim_seq_if.master        wb,
    output logic                     o_busy,
    output logic                     o_frame_done,
    output logic                     o_error,
    output logic [7:0]               o_frame_count
);

    localparam int unsigned TmoW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TmoW-1:0]            TmoLast  = TmoW'(ACK_TIMEOUT - 1);
    localparam logic [31:0]                TickLoad = 32'(FRAME_TICKS - 1);
    localparam logic [WB_ADDR_WIDTH-1:0]   LastRow  = '1;
    localparam logic [2*WB_DATA_WIDTH-1:0] SeedDbl  = {SEED, SEED};

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StAckWait,
        StDone,
        StWait,
        StError
    } state_e;

    state_e                   state_q;
    logic [WB_ADDR_WIDTH-1:0] row_q;
    logic [TmoW-1:0]          tmo_q;
    logic [31:0]              tick_q;
    logic [7:0]               frame_cnt_q;
    logic                     cyc_q;
    logic                     stb_q;
    logic                     busy_q;
    logic                     done_q;
    logic                     err_q;

    logic                       row_ack;
    logic                       tmo_hit;
    logic [2:0]                 rot_idx;
    logic [2*WB_DATA_WIDTH-1:0] rot_full;
    logic [WB_DATA_WIDTH-1:0]   pattern;

    // An ack counts in ISSUE only on the edge the request is accepted.
    always_comb begin
        row_ack = ((state_q == StIssue) && !wb.stall && wb.ack) ||
                  ((state_q == StAckWait) && wb.ack);
        tmo_hit = (tmo_q == TmoLast);
    end

    // Rotating the doubled seed left and keeping the top half is a rotate-left
    // of SEED by 4*((row + frame) mod 8).
    always_comb begin
        rot_idx  = row_q[2:0] + frame_cnt_q[2:0];
        rot_full = SeedDbl << {rot_idx, 2'b00};
        pattern  = rot_full[2*WB_DATA_WIDTH-1 -: WB_DATA_WIDTH];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            row_q       <= '0;
            tmo_q       <= '0;
            tick_q      <= '0;
            frame_cnt_q <= '0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (i_enable) begin
                        state_q <= StIssue;
                        row_q   <= '0;
                        tmo_q   <= '0;
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                StIssue, StAckWait: begin
                    if (row_ack) begin
                        if (row_q == LastRow) begin
                            state_q     <= StDone;
                            cyc_q       <= 1'b0;
                            stb_q       <= 1'b0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            frame_cnt_q <= frame_cnt_q + 8'd1;
                        end else begin
                            state_q <= StIssue;
                            row_q   <= row_q + 1'b1;
                            tmo_q   <= '0;
                            stb_q   <= 1'b1;
                        end
                    end else if (tmo_hit) begin
                        // Ack priority above: a last-cycle ack still completes the row.
                        state_q <= StError;
                        cyc_q   <= 1'b0;
                        stb_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                        if ((state_q == StIssue) && !wb.stall) begin
                            state_q <= StAckWait;
                            stb_q   <= 1'b0;
                        end
                    end
                end
                StDone: begin
                    if (i_enable) begin
                        state_q <= StWait;
                        tick_q  <= TickLoad;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StWait: begin
                    if (!i_enable) begin
                        state_q <= StIdle;
                    end else if (tick_q == '0) begin
                        state_q <= StIssue;
                        row_q   <= '0;
                        tmo_q   <= '0;
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        busy_q  <= 1'b1;
                    end else begin
                        tick_q <= tick_q - 32'd1;
                    end
                end
                StError: begin
                    if (i_clear_err) begin
                        err_q   <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Address/data/select are gated by stb so the bus reads all-zero when idle.
    assign wb.cyc   = cyc_q;
    assign wb.stb   = stb_q;
    assign wb.we    = stb_q;
    assign wb.sel   = {WB_SEL_WIDTH{stb_q}};
    assign wb.addr  = stb_q ? row_q : '0;
    assign wb.wdata = stb_q ? pattern : '0;

    assign o_busy        = busy_q;
    assign o_frame_done  = done_q;
    assign o_error       = err_q;
    assign o_frame_count = frame_cnt_q;

endmodule

// File: tb/tb_matrix_anim_seq.sv
// Directed bench for matrix_anim_seq with a small Wishbone slave model that
// acks one cycle after acceptance, can stall one row and can withhold an ack.
module tb_matrix_anim_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       clear_err = 1'b0;
    logic       busy;
    logic       frame_done;
    logic       error_flag;
    logic [7:0] frame_count;

    int n_tests = 0;
    int n_fail  = 0;
    int cycle   = 0;

    // Slave model controls.
    logic [3:0] stall_row   = 4'hF;
    logic [3:0] noack_row   = 4'hF;
    int         stall_limit = 0;
    int         stall_cnt   = 0;
    logic       ack_r       = 1'b0;

    logic [2:0]  log_addr[$];
    logic [31:0] log_data[$];

    matrix_anim_seq_if #(.WB_DATA_WIDTH(32), .WB_ADDR_WIDTH(3)) wb ();

    matrix_anim_seq #(
        .FRAME_TICKS(20),
        .ACK_TIMEOUT(16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_enable     (enable),
        .i_clear_err  (clear_err),
        .wb           (wb),
        .o_busy       (busy),
        .o_frame_done (frame_done),
        .o_error      (error_flag),
        .o_frame_count(frame_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    assign wb.stall = wb.stb && ({1'b0, wb.addr} == stall_row) && (stall_cnt < stall_limit);
    assign wb.ack   = ack_r;

    always @(posedge clk) begin
        if (wb.stall) stall_cnt <= stall_cnt + 1;
        if (wb.stb && !wb.stall) begin
            log_addr.push_back(wb.addr);
            log_data.push_back(wb.wdata);
            ack_r <= ({1'b0, wb.addr} != noack_row);
        end else begin
            ack_r <= 1'b0;
        end
    end

    typedef struct {
        int          idx;
        logic [2:0]  addr;
        logic [31:0] data;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_stb_addr(input logic [2:0] a, input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (wb.stb && (wb.addr == a)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_done(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (frame_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic count_stb(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (wb.stb || wb.cyc) n++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int t0;
        int n;
        int base;

        vecs[0]  = '{0,  3'd0, 32'h12345671};
        vecs[1]  = '{1,  3'd1, 32'h23456711};
        vecs[2]  = '{2,  3'd2, 32'h34567112};
        vecs[3]  = '{3,  3'd3, 32'h45671123};
        vecs[4]  = '{4,  3'd4, 32'h56711234};
        vecs[5]  = '{5,  3'd5, 32'h67112345};
        vecs[6]  = '{6,  3'd6, 32'h71123456};
        vecs[7]  = '{7,  3'd7, 32'h11234567};
        vecs[8]  = '{8,  3'd0, 32'h23456711};
        vecs[9]  = '{15, 3'd7, 32'h12345671};
        vecs[10] = '{30, 3'd6, 32'h23456711};
        vecs[11] = '{64, 3'd0, 32'h12345671};
        vecs[12] = '{69, 3'd5, 32'h67112345};
        vecs[13] = '{71, 3'd7, 32'h11234567};

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_cyc", wb.cyc, 0);
        check("rst_stb", wb.stb, 0);
        check("rst_we", wb.we, 0);
        check("rst_sel", wb.sel, 0);
        check("rst_addr", wb.addr, 0);
        check("rst_wdata", wb.wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        check("rst_error", error_flag, 0);
        check("rst_count", frame_count, 0);

        // Nominal frames.
        reset  = 1'b0;
        enable = 1'b1;
        wait_stb_addr(3'd0, 10, ok);
        check("first_issue_seen", ok, 1);
        t0 = cycle;
        check("first_busy", busy, 1);
        check("first_sel", wb.sel, 4'hF);
        check("first_we", wb.we, 1);
        wait_done(100, ok);
        check("done_seen", ok, 1);
        check("done_latency", cycle - t0, 16);
        check("done_count", frame_count, 1);
        check("done_cyc_low", wb.cyc, 0);
        wait_stb_addr(3'd0, 100, ok);
        check("next_issue_seen", ok, 1);
        check("start_to_start", cycle - t0, 37);
        for (int f = 1; f < 9; f++) begin
            wait_done(100, ok);
            check("frame_done_seen", ok, 1);
        end
        check("nine_frames_count", frame_count, 9);

        // Drop enable in WAIT: no further bus activity.
        repeat (2) @(negedge clk);
        enable = 1'b0;
        count_stb(40, n);
        check("wait_drop_idle", n, 0);
        check("log_size_9_frames", log_data.size(), 72);

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].idx < log_data.size()) begin
                check($sformatf("vec%0d_addr", i), log_addr[vecs[i].idx], vecs[i].addr);
                check($sformatf("vec%0d_data", i), log_data[vecs[i].idx], vecs[i].data);
            end else begin
                check($sformatf("vec%0d_present", i), 0, 1);
            end
        end

        // Stall row 2 for 3 cycles in frame 9 (f[2:0] = 1).
        stall_row   = 4'd2;
        stall_limit = stall_cnt + 3;
        base        = log_data.size();
        enable      = 1'b1;
        wait_stb_addr(3'd0, 10, ok);
        check("stall_issue_seen", ok, 1);
        t0 = cycle;
        wait_stb_addr(3'd2, 20, ok);
        check("stall_row_seen", ok, 1);
        for (int i = 0; i < 4; i++) begin
            check("stall_stb_held", wb.stb, 1);
            check("stall_addr_held", wb.addr, 2);
            check("stall_data_held", wb.wdata, 32'h45671123);
            @(negedge clk);
        end
        check("stall_stb_released", wb.stb, 0);
        wait_done(100, ok);
        check("stall_done_seen", ok, 1);
        check("stall_done_latency", cycle - t0, 19);
        check("stall_count", frame_count, 10);
        check("stall_no_dup", log_data.size() - base, 8);
        enable    = 1'b0;
        stall_row = 4'hF;
        repeat (3) @(negedge clk);

        // Never ack row 4 in frame 10 (f[2:0] = 2).
        noack_row = 4'd4;
        enable    = 1'b1;
        wait_stb_addr(3'd4, 40, ok);
        check("tmo_row_seen", ok, 1);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!wb.cyc) break;
            n++;
            @(negedge clk);
        end
        check("tmo_cyc_cycles", n, 16);
        check("tmo_error", error_flag, 1);
        check("tmo_busy", busy, 0);
        check("tmo_count", frame_count, 10);
        noack_row = 4'hF;
        count_stb(5, n);
        check("tmo_bus_idle", n, 0);
        check("tmo_error_sticky", error_flag, 1);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        check("clear_error", error_flag, 0);
        base = log_data.size();
        wait_stb_addr(3'd0, 10, ok);
        check("restart_seen", ok, 1);
        check("restart_data", wb.wdata, 32'h34567112);

        // Drop enable during row 3: frame still completes.
        wait_stb_addr(3'd3, 20, ok);
        check("drop_row3_seen", ok, 1);
        enable = 1'b0;
        wait_done(100, ok);
        check("drop_done_seen", ok, 1);
        check("drop_count", frame_count, 11);
        check("drop_rows_written", log_data.size() - base, 8);
        check("drop_last_addr", log_addr[log_addr.size()-1], 7);
        check("drop_last_data", log_data[log_data.size()-1], 32'h23456711);
        count_stb(40, n);
        check("drop_idle_after", n, 0);

        // Asynchronous reset mid-transaction.
        enable = 1'b1;
        wait_stb_addr(3'd2, 30, ok);
        check("arst_row_seen", ok, 1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_cyc", wb.cyc, 0);
        check("arst_stb", wb.stb, 0);
        check("arst_busy", busy, 0);
        check("arst_count", frame_count, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_stb_addr(3'd0, 10, ok);
        check("arst_restart_seen", ok, 1);
        check("arst_restart_data", wb.wdata, 32'h12345671);
        check("arst_restart_count", frame_count, 0);
        enable = 1'b0;
        repeat (40) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
